// File: rtl/cxu_fxp_mac.sv
// rtl/cxu_fxp_mac.sv - fixed-point multiply/accumulate custom function unit
// One command in flight; results scaled by FRAC_W and optionally saturated.
module cxu_fxp_mac #(
   parameter int DATA_W      = 32,
   parameter int FRAC_W      = 10,
   parameter int ACC_W       = 64,
   parameter int NUM_STATES  = 8,
   parameter int PIPE_STAGES = 2,
   parameter int SAT_EN      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_payload_function_id,
   input  logic [DATA_W-1:0] cmd_payload_inputs_0,
   input  logic [DATA_W-1:0] cmd_payload_inputs_1,
   input  logic [2:0]        cmd_payload_state_id,
   input  logic [3:0]        cmd_payload_cxu_id,
   input  logic              cmd_payload_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_payload_outputs_0,
   output logic              rsp_payload_ready
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int PIPE_N = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
   localparam int LAST   = PIPE_N - 1;
   localparam int CNT_W  = (PIPE_STAGES > 2) ? $clog2(PIPE_STAGES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   state_t                    state;
   logic [CNT_W-1:0]          cnt;
   logic [2:0]                op_q;
   logic [2:0]                s_q;
   logic [DATA_W-1:0]         a_q;
   logic signed [2*DATA_W-1:0] p_pipe [PIPE_N];
   logic signed [ACC_W-1:0]   acc [8];
   logic [DATA_W-1:0]         rsp_out;

   logic                      accept;
   logic                      commit;
   logic signed [2*DATA_W-1:0] prod_in;
   logic signed [2*DATA_W-1:0] p_cur;
   logic [2:0]                cur_op;
   logic [2:0]                cur_s;
   logic [DATA_W-1:0]         cur_a;
   logic                      s_ok;
   logic signed [ACC_W-1:0]   acc_rd;
   logic signed [ACC_W-1:0]   p_ext;
   logic signed [ACC_W-1:0]   mac_sum;
   logic signed [ACC_W-1:0]   acc_wr;
   logic                      wr_en;
   logic [DATA_W-1:0]         result;
   logic                      unused_ign;

   assign unused_ign = ^{cmd_payload_cxu_id, cmd_payload_ready};

   assign prod_in = (2*DATA_W)'($signed(cmd_payload_inputs_0)) *
                    (2*DATA_W)'($signed(cmd_payload_inputs_1));
   assign accept  = (state == IDLE) && cmd_valid;

   // A single-stage pipe resolves on the accept edge itself, straight from the bus.
   assign commit = (PIPE_STAGES == 1) ? accept : ((state == BUSY) && (cnt == CNT_LAST));
   assign cur_op = (PIPE_STAGES == 1) ? cmd_payload_function_id : op_q;
   assign cur_s  = (PIPE_STAGES == 1) ? cmd_payload_state_id : s_q;
   assign cur_a  = (PIPE_STAGES == 1) ? cmd_payload_inputs_0 : a_q;
   assign p_cur  = (PIPE_STAGES == 1) ? prod_in : p_pipe[LAST];

   function automatic logic [DATA_W-1:0] fmt(input logic signed [ACC_W-1:0] x);
      logic signed [ACC_W-1:0] sh;
      sh = x >>> FRAC_W;
      if (SAT_EN != 0) begin
         if (sh > SAT_MAX) sh = SAT_MAX;
         else if (sh < SAT_MIN) sh = SAT_MIN;
      end
      return sh[DATA_W-1:0];
   endfunction

   always_comb begin
      s_ok    = int'(cur_s) < NUM_STATES;
      acc_rd  = s_ok ? acc[cur_s] : '0;
      p_ext   = ACC_W'(p_cur);
      mac_sum = acc_rd + p_ext;
      acc_wr  = '0;
      wr_en   = 1'b0;
      result  = '0;
      case (cur_op)
         3'd0: result = fmt(p_ext);
         3'd1: begin
            acc_wr = mac_sum;
            wr_en  = s_ok;
            result = fmt(mac_sum);
         end
         3'd2: result = fmt(acc_rd);
         3'd3: wr_en = s_ok;
         3'd4: begin
            acc_wr = ACC_W'($signed(cur_a)) <<< FRAC_W;
            wr_en  = s_ok;
            result = cur_a;
         end
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= '0;
         s_q     <= '0;
         a_q     <= '0;
         rsp_out <= '0;
         for (int i = 0; i < PIPE_N; i++) p_pipe[i] <= '0;
         for (int i = 0; i < 8; i++) acc[i] <= '0;
      end else begin
         for (int i = 1; i < PIPE_N; i++) p_pipe[i] <= p_pipe[i-1];
         case (state)
            IDLE: if (cmd_valid) begin
               op_q      <= cmd_payload_function_id;
               s_q       <= cmd_payload_state_id;
               a_q       <= cmd_payload_inputs_0;
               p_pipe[0] <= prod_in;
               cnt       <= '0;
               state     <= (PIPE_STAGES == 1) ? RESP : BUSY;
            end
            BUSY: begin
               if (cnt == CNT_LAST) state <= RESP;
               else cnt <= cnt + 1'b1;
            end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (commit) begin
            rsp_out <= result;
            if (wr_en) acc[cur_s] <= acc_wr;
         end
      end
   end

   assign cmd_ready             = (state == IDLE);
   assign rsp_valid             = (state == RESP);
   assign rsp_payload_outputs_0 = rsp_out;
   assign rsp_payload_ready     = 1'b1;

endmodule

// File: tb/tb_cxu_fxp_mac.sv
// tb/tb_cxu_fxp_mac.sv - self-checking bench for cxu_fxp_mac
// Drives a saturating/8-state unit and a truncating/4-state unit from one command bus.
module tb_cxu_fxp_mac;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [2:0]  fid = '0;
   logic [31:0] in0 = '0;
   logic [31:0] in1 = '0;
   logic [2:0]  sid = '0;
   logic [3:0]  cxu = '0;
   logic        cpr = 1'b0;
   logic        rsp_ready = 1'b1;

   logic        cr0, rv0, prr0, cr1, rv1, prr1;
   logic [31:0] out0, out1;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cxu_fxp_mac dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cr0),
      .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0),
      .cmd_payload_inputs_1(in1), .cmd_payload_state_id(sid),
      .cmd_payload_cxu_id(cxu), .cmd_payload_ready(cpr),
      .rsp_valid(rv0), .rsp_ready(rsp_ready),
      .rsp_payload_outputs_0(out0), .rsp_payload_ready(prr0)
   );

   cxu_fxp_mac #(.SAT_EN(0), .NUM_STATES(4)) dut_ns (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cr1),
      .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0),
      .cmd_payload_inputs_1(in1), .cmd_payload_state_id(sid),
      .cmd_payload_cxu_id(cxu), .cmd_payload_ready(cpr),
      .rsp_valid(rv1), .rsp_ready(rsp_ready),
      .rsp_payload_outputs_0(out1), .rsp_payload_ready(prr1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit integer arithmetic per instance
   longint macc [2][8];

   function automatic logic [31:0] mfmt(input longint x, input bit sat);
      longint sh;
      sh = x >>> 10;
      if (sat) begin
         if (sh > 64'sd2147483647) return 32'h7fffffff;
         if (sh < -64'sd2147483648) return 32'h80000000;
      end
      return sh[31:0];
   endfunction

   function automatic logic [31:0] model(input int inst, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] s);
      longint p, cur;
      bit ok, sat;
      logic [31:0] r;
      sat = (inst == 0);
      ok  = int'(s) < ((inst == 0) ? 8 : 4);
      p   = longint'($signed(a)) * longint'($signed(b));
      cur = ok ? macc[inst][s] : 64'sd0;
      r   = '0;
      case (op)
         3'd0: r = mfmt(p, sat);
         3'd1: begin
            cur = cur + p;
            if (ok) macc[inst][s] = cur;
            r = mfmt(cur, sat);
         end
         3'd2: r = mfmt(cur, sat);
         3'd3: if (ok) macc[inst][s] = 0;
         3'd4: begin
            if (ok) macc[inst][s] = longint'($signed(a)) * 1024;
            r = a;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 8; j++) macc[i][j] = 0;
   endtask

   // Called #1 after a rising edge with the unit idle; returns the same way.
   task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s, input int hold,
                         output logic [31:0] r0, output logic [31:0] r1);
      int k;
      check("idle_cmd_ready", {cr0, cr1}, 2'b11);
      rsp_ready = (hold == 0);
      cmd_valid = 1'b1; fid = op; in0 = a; in1 = b; sid = s;
      cxu = 4'($urandom); cpr = 1'($urandom);
      @(posedge clk); #1;
      cmd_valid = 1'($urandom); fid = 3'($urandom); in0 = $urandom; in1 = $urandom;
      sid = 3'($urandom);
      check("busy_cmd_ready", {cr0, cr1}, 2'b00);
      check("busy_rsp_valid", {rv0, rv1}, 2'b00);
      @(posedge clk); #1;
      check("rsp_valid_latency", {rv0, rv1}, 2'b11);
      check("resp_cmd_ready", {cr0, cr1}, 2'b00);
      r0 = out0; r1 = out1;
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; fid = 3'($urandom); in0 = $urandom; in1 = $urandom;
         @(posedge clk); #1;
         check("hold_rsp_valid", {rv0, rv1}, 2'b11);
         check("hold_cmd_ready", {cr0, cr1}, 2'b00);
         check("hold_output", {out0, out1}, {r0, r1});
      end
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rsp", {cr0, cr1, rv0, rv1}, 4'b1100);
      k = 0;
      while (!(cr0 === 1'b1 && cr1 === 1'b1) && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (k == 20) begin
         $display("FAIL idle_timeout: unit never returned to idle");
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
         $fatal(1);
      end
   endtask

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  s;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [31:0] r0, r1, m0, m1, held;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [2:0]  s;
      int          hold;

      tbl.push_back('{"mulsh_basic", 3'd0, 32'd3072, 32'd2048, 3'd0, 32'd6144, 32'd6144});
      tbl.push_back('{"mulsh_neg_floor", 3'd0, 32'hffffffff, 32'd1, 3'd0, 32'hffffffff, 32'hffffffff});
      tbl.push_back('{"mulsh_neg3", 3'd0, 32'hfffffffd, 32'd1, 3'd0, 32'hffffffff, 32'hffffffff});
      tbl.push_back('{"mulsh_sat_pos", 3'd0, 32'h7fffffff, 32'h7fffffff, 3'd0, 32'h7fffffff, 32'hffc00000});
      tbl.push_back('{"mulsh_sat_neg", 3'd0, 32'h80000000, 32'h7fffffff, 3'd0, 32'h80000000, 32'h00200000});
      tbl.push_back('{"clr_s2", 3'd3, 32'd9, 32'd9, 3'd2, 32'd0, 32'd0});
      tbl.push_back('{"mac1_s2", 3'd1, 32'd1024, 32'd2048, 3'd2, 32'd2048, 32'd2048});
      tbl.push_back('{"mac2_s2", 3'd1, 32'd1024, 32'd2048, 3'd2, 32'd4096, 32'd4096});
      tbl.push_back('{"rdacc_s2", 3'd2, 32'd0, 32'd0, 3'd2, 32'd4096, 32'd4096});
      tbl.push_back('{"rdacc_s3", 3'd2, 32'd0, 32'd0, 3'd3, 32'd0, 32'd0});
      tbl.push_back('{"setacc_s2", 3'd4, 32'd5, 32'd0, 3'd2, 32'd5, 32'd5});
      tbl.push_back('{"rdacc_s2_set", 3'd2, 32'd0, 32'd0, 3'd2, 32'd5, 32'd5});
      tbl.push_back('{"setacc_s5", 3'd4, 32'd7, 32'd0, 3'd5, 32'd7, 32'd7});
      tbl.push_back('{"rdacc_s5", 3'd2, 32'd0, 32'd0, 3'd5, 32'd7, 32'd0});
      tbl.push_back('{"mac_s5", 3'd1, 32'd1024, 32'd1024, 3'd5, 32'd1031, 32'd1024});
      tbl.push_back('{"clr_s1", 3'd3, 32'd0, 32'd0, 3'd1, 32'd0, 32'd0});
      tbl.push_back('{"mac_big1", 3'd1, 32'h80000000, 32'h80000000, 3'd1, 32'h7fffffff, 32'd0});
      tbl.push_back('{"mac_wrap", 3'd1, 32'h80000000, 32'h80000000, 3'd1, 32'h80000000, 32'd0});
      tbl.push_back('{"rdacc_wrap", 3'd2, 32'd0, 32'd0, 3'd1, 32'h80000000, 32'd0});
      tbl.push_back('{"op5", 3'd5, 32'd1, 32'd1, 3'd0, 32'd0, 32'd0});
      tbl.push_back('{"op7", 3'd7, 32'd3072, 32'd2048, 3'd0, 32'd0, 32'd0});
      tbl.push_back('{"setacc_neg", 3'd4, 32'hffffffff, 32'd0, 3'd0, 32'hffffffff, 32'hffffffff});
      tbl.push_back('{"rdacc_neg", 3'd2, 32'd0, 32'd0, 3'd0, 32'hffffffff, 32'hffffffff});

      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp_valid", {rv0, rv1}, 2'b00);
      reset = 1'b1;
      check("post_reset_cmd_ready", {cr0, cr1}, 2'b11);
      check("post_reset_rsp_valid", {rv0, rv1}, 2'b00);
      check("post_reset_payload_ready", {prr0, prr1}, 2'b11);
      check("post_reset_output", {out0, out1}, 64'd0);

      foreach (tbl[i]) begin
         do_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s, 0, r0, r1);
         m0 = model(0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s);
         m1 = model(1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s);
         check({tbl[i].name, "_sat"}, r0, tbl[i].e0);
         check({tbl[i].name, "_trunc"}, r1, tbl[i].e1);
      end

      // Backpressure: response held for 5 cycles with a competing command on the bus
      do_cmd(3'd0, 32'd3072, 32'd2048, 3'd0, 5, r0, r1);
      check("backpressure_sat", r0, 32'd6144);
      check("backpressure_trunc", r1, 32'd6144);

      for (int n = 0; n < 150; n++) begin
         op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         if ($urandom_range(0, 1) == 0) begin
            a = 32'($urandom_range(0, 10000)) - 32'd5000;
            b = 32'($urandom_range(0, 10000)) - 32'd5000;
         end else begin
            a = $urandom;
            b = $urandom;
         end
         s = 3'($urandom_range(0, 7));
         hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
         do_cmd(op, a, b, s, hold, r0, r1);
         m0 = model(0, op, a, b, s);
         m1 = model(1, op, a, b, s);
         check($sformatf("rand%0d_op%0d_sat", n, op), r0, m0);
         check($sformatf("rand%0d_op%0d_trunc", n, op), r1, m1);
      end

      // Reset lands in the busy cycle of a MAC: no response, no update
      do_cmd(3'd4, 32'd3, 32'd0, 3'd3, 0, r0, r1);
      m0 = model(0, 3'd4, 32'd3, 32'd0, 3'd3);
      m1 = model(1, 3'd4, 32'd3, 32'd0, 3'd3);
      cmd_valid = 1'b1; fid = 3'd1; in0 = 32'd1024; in1 = 32'd1024; sid = 3'd3;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      clear_model();
      check("midreset_rsp_valid", {rv0, rv1}, 2'b00);
      check("midreset_cmd_ready", {cr0, cr1}, 2'b11);
      check("midreset_output", {out0, out1}, 64'd0);
      @(posedge clk); #1;
      check("midreset_no_late_rsp", {rv0, rv1}, 2'b00);
      held = model(0, 3'd2, 32'd0, 32'd0, 3'd3);
      do_cmd(3'd2, 32'd0, 32'd0, 3'd3, 0, r0, r1);
      check("midreset_rdacc_sat", r0, 32'd0);
      check("midreset_rdacc_trunc", r1, 32'd0);
      check("midreset_rdacc_model", r0, held);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
